// File: rtl/gtlb_arbiter_pkg.sv
// Shared types for the G-stage TLB arbiter: PTE layout, GTLB refill record
// and controller state encoding.
package gtlb_arbiter_pkg;

    localparam int unsigned GPLEN          = 41;
    localparam int unsigned GPPN_WIDTH     = GPLEN - 12;
    localparam int unsigned VMID_MAX_WIDTH = 14;

    typedef struct packed {
        logic [9:0]  reserved;
        logic [43:0] ppn;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } pte_t;

    typedef struct packed {
        logic                      valid;
        logic                      is_2M;
        logic                      is_1G;
        logic [GPPN_WIDTH-1:0]     gppn;
        logic [VMID_MAX_WIDTH-1:0] vmid;
        pte_t                      content;
    } gtlb_update_t;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WALK_REQ,
        WALK_WAIT,
        RESP,
        FENCE
    } gtlb_arb_state_e;

    function automatic logic [1:0] port_mask(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/gtlb_arbiter_rr_arb_2.sv
// Two-requester round-robin arbiter; the pointer moves to the losing side
// after every grant so simultaneous requesters alternate.
module rr_arb_2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o,
    output logic       id_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        id_o  = req_i[ptr_q] ? ptr_q : ~ptr_q;
        gnt_o = '0;
        ptr_d = ptr_q;
        if (en_i && (req_i != 2'b00)) begin
            gnt_o = id_o ? 2'b10 : 2'b01;
            ptr_d = ~id_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/gtlb_arbiter.sv
// Shares the G-stage TLB between the instruction and data/VS-walker
// requesters: lookup, walk on miss with refill, and serialised HFENCE flushes.
module gtlb_arbiter
    import gtlb_arbiter_pkg::*;
#(
    parameter int unsigned VMID_WIDTH = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [1:0]                     req_valid_i,
    input  logic [1:0][GPLEN-1:0]          req_gpaddr_i,
    input  logic [1:0][VMID_WIDTH-1:0]     req_vmid_i,
    output logic [1:0]                     req_ready_o,
    output logic [1:0]                     rsp_valid_o,
    output pte_t                           rsp_pte_o,
    output logic                           rsp_is_2M_o,
    output logic                           rsp_is_1G_o,
    output logic                           rsp_err_o,
    input  logic                           fence_valid_i,
    output logic                           fence_ready_o,
    input  logic                           fence_is_vvma_i,
    input  logic [VMID_WIDTH-1:0]          fence_vmid_i,
    input  logic [GPLEN-1:0]               fence_gpaddr_i,
    output logic                           gtlb_access_o,
    output logic [VMID_WIDTH-1:0]          gtlb_vmid_o,
    output logic [GPLEN-1:0]               gtlb_gpaddr_o,
    input  logic                           gtlb_hit_i,
    input  pte_t                           gtlb_content_i,
    input  logic                           gtlb_is_2M_i,
    input  logic                           gtlb_is_1G_i,
    output logic                           gtlb_flush_o,
    output logic                           gtlb_flush_vvma_o,
    output logic [VMID_WIDTH-1:0]          gtlb_flush_vmid_o,
    output logic [GPLEN-1:0]               gtlb_flush_gpaddr_o,
    output gtlb_update_t                   gtlb_update_o,
    output logic                           walk_req_valid_o,
    input  logic                           walk_req_ready_i,
    output logic [GPLEN-1:0]               walk_gpaddr_o,
    output logic [VMID_WIDTH-1:0]          walk_vmid_o,
    input  logic                           walk_rsp_valid_i,
    input  pte_t                           walk_rsp_pte_i,
    input  logic                           walk_rsp_is_2M_i,
    input  logic                           walk_rsp_is_1G_i,
    input  logic                           walk_rsp_err_i
);

    gtlb_arb_state_e state_q, state_d;

    logic [GPLEN-1:0]      req_gpaddr_q, req_gpaddr_d;
    logic [VMID_WIDTH-1:0] req_vmid_q, req_vmid_d;
    logic                  id_q, id_d;
    logic [VMID_WIDTH-1:0] fence_vmid_q, fence_vmid_d;

    logic [1:0]            rsp_valid_q, rsp_valid_d;
    pte_t                  rsp_pte_q, rsp_pte_d;
    logic                  rsp_is_2M_q, rsp_is_2M_d;
    logic                  rsp_is_1G_q, rsp_is_1G_d;
    logic                  rsp_err_q, rsp_err_d;
    gtlb_update_t          update_q, update_d;
    logic                  walk_valid_q, walk_valid_d;
    logic [GPLEN-1:0]      walk_gpaddr_q, walk_gpaddr_d;
    logic [VMID_WIDTH-1:0] walk_vmid_q, walk_vmid_d;
    logic                  flush_q, flush_d;
    logic                  flush_vvma_q, flush_vvma_d;
    logic [VMID_WIDTH-1:0] flush_vmid_q, flush_vmid_d;
    logic [GPLEN-1:0]      flush_gpaddr_q, flush_gpaddr_d;

    logic       arb_en;
    logic [1:0] arb_gnt;
    logic       arb_id;

    rr_arb_2 u_rr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (req_valid_i),
        .en_i  (arb_en),
        .gnt_o (arb_gnt),
        .id_o  (arb_id)
    );

    // Ready strobes are masked during reset so every output reads zero.
    always_comb begin
        arb_en        = (state_q == IDLE) && !fence_valid_i && !rst_i;
        fence_ready_o = (state_q == IDLE) && !rst_i;
        req_ready_o   = arb_gnt;
        gtlb_access_o = (state_q == LOOKUP);
        gtlb_gpaddr_o = gtlb_access_o ? req_gpaddr_q : '0;
        gtlb_vmid_o   = '0;
        if (gtlb_access_o) begin
            gtlb_vmid_o = req_vmid_q;
        end else if (flush_vvma_q) begin
            gtlb_vmid_o = fence_vmid_q;
        end
    end

    always_comb begin
        state_d        = state_q;
        req_gpaddr_d   = req_gpaddr_q;
        req_vmid_d     = req_vmid_q;
        id_d           = id_q;
        fence_vmid_d   = fence_vmid_q;
        rsp_valid_d    = '0;
        rsp_pte_d      = rsp_pte_q;
        rsp_is_2M_d    = rsp_is_2M_q;
        rsp_is_1G_d    = rsp_is_1G_q;
        rsp_err_d      = rsp_err_q;
        update_d       = '0;
        walk_valid_d   = 1'b0;
        walk_gpaddr_d  = '0;
        walk_vmid_d    = '0;
        flush_d        = 1'b0;
        flush_vvma_d   = 1'b0;
        flush_vmid_d   = '0;
        flush_gpaddr_d = '0;

        unique case (state_q)
            IDLE: begin
                if (fence_valid_i) begin
                    fence_vmid_d = fence_vmid_i;
                    state_d      = FENCE;
                    if (fence_is_vvma_i) begin
                        flush_vvma_d = 1'b1;
                    end else begin
                        flush_d        = 1'b1;
                        flush_vmid_d   = fence_vmid_i;
                        flush_gpaddr_d = fence_gpaddr_i;
                    end
                end else if (arb_gnt != 2'b00) begin
                    req_gpaddr_d = req_gpaddr_i[arb_id];
                    req_vmid_d   = req_vmid_i[arb_id];
                    id_d         = arb_id;
                    state_d      = LOOKUP;
                end
            end
            LOOKUP: begin
                if (gtlb_hit_i) begin
                    rsp_valid_d = port_mask(id_q);
                    rsp_pte_d   = gtlb_content_i;
                    rsp_is_2M_d = gtlb_is_2M_i;
                    rsp_is_1G_d = gtlb_is_1G_i;
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
                end else begin
                    walk_valid_d  = 1'b1;
                    walk_gpaddr_d = req_gpaddr_q;
                    walk_vmid_d   = req_vmid_q;
                    state_d       = WALK_REQ;
                end
            end
            WALK_REQ: begin
                if (walk_req_ready_i) begin
                    state_d = WALK_WAIT;
                end else begin
                    walk_valid_d  = 1'b1;
                    walk_gpaddr_d = req_gpaddr_q;
                    walk_vmid_d   = req_vmid_q;
                end
            end
            WALK_WAIT: begin
                if (walk_rsp_valid_i) begin
                    rsp_valid_d = port_mask(id_q);
                    rsp_pte_d   = walk_rsp_pte_i;
                    rsp_is_2M_d = walk_rsp_is_2M_i;
                    rsp_is_1G_d = walk_rsp_is_1G_i;
                    rsp_err_d   = walk_rsp_err_i;
                    state_d     = RESP;
                    if (!walk_rsp_err_i) begin
                        update_d.valid   = 1'b1;
                        update_d.is_2M   = walk_rsp_is_2M_i;
                        update_d.is_1G   = walk_rsp_is_1G_i;
                        update_d.gppn    = req_gpaddr_q[GPLEN-1:12];
                        update_d.vmid    = VMID_MAX_WIDTH'(req_vmid_q);
                        update_d.content = walk_rsp_pte_i;
                    end
                end
            end
            RESP:    state_d = IDLE;
            FENCE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            req_gpaddr_q   <= '0;
            req_vmid_q     <= '0;
            id_q           <= 1'b0;
            fence_vmid_q   <= '0;
            rsp_valid_q    <= '0;
            rsp_pte_q      <= '0;
            rsp_is_2M_q    <= 1'b0;
            rsp_is_1G_q    <= 1'b0;
            rsp_err_q      <= 1'b0;
            update_q       <= '0;
            walk_valid_q   <= 1'b0;
            walk_gpaddr_q  <= '0;
            walk_vmid_q    <= '0;
            flush_q        <= 1'b0;
            flush_vvma_q   <= 1'b0;
            flush_vmid_q   <= '0;
            flush_gpaddr_q <= '0;
        end else begin
            state_q        <= state_d;
            req_gpaddr_q   <= req_gpaddr_d;
            req_vmid_q     <= req_vmid_d;
            id_q           <= id_d;
            fence_vmid_q   <= fence_vmid_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_pte_q      <= rsp_pte_d;
            rsp_is_2M_q    <= rsp_is_2M_d;
            rsp_is_1G_q    <= rsp_is_1G_d;
            rsp_err_q      <= rsp_err_d;
            update_q       <= update_d;
            walk_valid_q   <= walk_valid_d;
            walk_gpaddr_q  <= walk_gpaddr_d;
            walk_vmid_q    <= walk_vmid_d;
            flush_q        <= flush_d;
            flush_vvma_q   <= flush_vvma_d;
            flush_vmid_q   <= flush_vmid_d;
            flush_gpaddr_q <= flush_gpaddr_d;
        end
    end

    assign rsp_valid_o         = rsp_valid_q;
    assign rsp_pte_o           = rsp_pte_q;
    assign rsp_is_2M_o         = rsp_is_2M_q;
    assign rsp_is_1G_o         = rsp_is_1G_q;
    assign rsp_err_o           = rsp_err_q;
    assign gtlb_update_o       = update_q;
    assign walk_req_valid_o    = walk_valid_q;
    assign walk_gpaddr_o       = walk_gpaddr_q;
    assign walk_vmid_o         = walk_vmid_q;
    assign gtlb_flush_o        = flush_q;
    assign gtlb_flush_vvma_o   = flush_vvma_q;
    assign gtlb_flush_vmid_o   = flush_vmid_q;
    assign gtlb_flush_gpaddr_o = flush_gpaddr_q;

endmodule
